// File: rtl/tick_period_meter.sv
`default_nettype none
// ============================================================================
// Module   : tick_period_meter
// Purpose  : Measures period and high time of a slow asynchronous tick in clk
//            cycles. Define PERIOD_METER_CONT_EN for continuous measurement.
// Revision : 1.0  initial release
// ============================================================================
module tick_period_meter #(
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_ONE;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   s_sync;
  logic                   rise;
  logic                   fall;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       hi_cap_q;
  logic                   fall_seen_q;
  logic                   busy_q;
  logic                   done_q;
  logic [CNT_W-1:0]       period_q;
  logic [CNT_W-1:0]       high_q;
  logic                   ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~hist_q;
  assign fall   = ~s_sync & hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      fall_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      period_q    <= '0;
      high_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (rise) begin
            state_q     <= ST_MEASURE;
            cnt_q       <= CNT_ONE;
            fall_seen_q <= 1'b0;
          // timeout fires on the same edge the counter reaches all-ones
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_MAX;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            ovf_q    <= 1'b1;
            period_q <= '0;
            high_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        ST_MEASURE: begin
          if (rise) begin
            period_q <= cnt_q;
            high_q   <= hi_cap_q;
            ovf_q    <= 1'b0;
            done_q   <= 1'b1;
`ifdef PERIOD_METER_CONT_EN
            // terminating rise opens the next period
            cnt_q       <= CNT_ONE;
            fall_seen_q <= 1'b0;
`else
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
`endif
          end else if (cnt_q == CNT_MAX) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            ovf_q    <= 1'b1;
            period_q <= CNT_MAX;
            high_q   <= fall_seen_q ? hi_cap_q : CNT_MAX;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
            if (fall && !fall_seen_q) begin
              hi_cap_q    <= cnt_q;
              fall_seen_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_period_meter.sv
`default_nettype none
// Directed and randomized checks of tick_period_meter on a wide (20-bit) and
// a narrow (8-bit) counter build, against expectations derived from the stimulus.
`timescale 1ns/1ps
module tb_tick_period_meter;

  localparam int AW = 20;
  localparam int BW = 8;
  localparam int BMAX = 255;
`ifdef PERIOD_METER_CONT_EN
  localparam int CONT = 1;
`else
  localparam int CONT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_tick, a_start, a_busy, a_done, a_ovf;
  logic [AW-1:0] a_period, a_high;
  logic          b_tick, b_start, b_busy, b_done, b_ovf;
  logic [BW-1:0] b_period, b_high;

  tick_period_meter #(.CNT_W(AW), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tick_in(a_tick), .start(a_start),
    .busy(a_busy), .done(a_done), .period(a_period), .high_time(a_high),
    .overflow(a_ovf)
  );

  tick_period_meter #(.CNT_W(BW), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tick_in(b_tick), .start(b_start),
    .busy(b_busy), .done(b_done), .period(b_period), .high_time(b_high),
    .overflow(b_ovf)
  );

  typedef struct {
    int cyc;
    int period;
    int high;
    int ovf;
    int busy;
  } rec_t;

  rec_t qa[$];
  rec_t qb[$];
  rec_t mon_rec;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   dbl_done = 0;
  logic a_prev = 1'b0;
  logic b_prev = 1'b0;

  // Capture every done pulse with the posedge index it appeared on.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (a_done) begin
      mon_rec.cyc = cyc; mon_rec.period = int'(a_period); mon_rec.high = int'(a_high);
      mon_rec.ovf = int'(a_ovf); mon_rec.busy = int'(a_busy);
      qa.push_back(mon_rec);
    end
    if (b_done) begin
      mon_rec.cyc = cyc; mon_rec.period = int'(b_period); mon_rec.high = int'(b_high);
      mon_rec.ovf = int'(b_ovf); mon_rec.busy = int'(b_busy);
      qb.push_back(mon_rec);
    end
    if ((a_done && a_prev) || (b_done && b_prev)) dbl_done++;
    a_prev = a_done;
    b_prev = b_done;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input bit sel);
    return sel ? qb.size() : qa.size();
  endfunction

  function automatic rec_t rec_at(input bit sel, input int i);
    rec_t r;
    r.cyc = -1; r.period = -1; r.high = -1; r.ovf = -1; r.busy = -1;
    if (sel) begin
      if (i < qb.size()) r = qb[i];
    end else begin
      if (i < qa.size()) r = qa[i];
    end
    return r;
  endfunction

  // Drive one constant tick level for n cycles; start pulses at index start_at.
  task automatic seg(input bit sel, input bit lvl, input int n, input int start_at);
    for (int i = 0; i < n; i++) begin
      if (sel) begin b_tick = lvl; b_start = (i == start_at); end
      else     begin a_tick = lvl; a_start = (i == start_at); end
      @(negedge clk);
    end
    if (sel) b_start = 1'b0; else a_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input int budget, input string tag);
    int n;
    n = 0;
    while (qsize(sel) == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_arrived"}, int'(qsize(sel) != 0), 1);
  endtask

  task automatic reset_all();
    a_tick = 1'b0; b_tick = 1'b0; a_start = 1'b0; b_start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    rec_t r;
    int   t0, p, h, l, ep, eh, eo;

    rst_n = 1'b0;
    a_tick = 1'b0; a_start = 1'b0; b_tick = 1'b0; b_start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_done", int'(a_done), 0);
    check("rst_a_period", int'(a_period), 0);
    check("rst_a_high", int'(a_high), 0);
    check("rst_a_ovf", int'(a_ovf), 0);
    check("rst_b_busy", int'(b_busy), 0);
    check("rst_b_period", int'(b_period), 0);
    check("rst_b_ovf", int'(b_ovf), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_a_busy", int'(a_busy), 0);

    // Divider-style tick: period 65536, high 15536.
    seg(0, 0, 10, 0);
    seg(0, 1, 15536, -1);
    seg(0, 0, 50000, -1);
    seg(0, 1, 5, -1);
    seg(0, 0, 5, -1);
    wait_done(0, 10, "div");
    r = rec_at(0, 0);
    check("div_period", r.period, 65536);
    check("div_high", r.high, 15536);
    check("div_ovf", r.ovf, 0);
    check("div_busy_at_done", r.busy, CONT);
    repeat (20) @(negedge clk);
    check("div_count", qsize(0), 1);
    check("div_hold_period", int'(a_period), 65536);
    check("div_hold_high", int'(a_high), 15536);

    // Asynchronous reset while a measurement is in progress.
    reset_all();
    seg(0, 0, 4, 0);
    seg(0, 1, 3, -1);
    seg(0, 0, 4, -1);
    seg(0, 1, 3, -1);
    seg(0, 0, 4, 0);
    seg(0, 1, 4, -1);
    check("pre_rst_busy", int'(a_busy), 1);
    check("pre_rst_period", int'(a_period), 7);
    check("pre_rst_high", int'(a_high), 3);
    qa.delete();
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(a_busy), 0);
    check("arst_done", int'(a_done), 0);
    check("arst_period", int'(a_period), 0);
    check("arst_high", int'(a_high), 0);
    check("arst_ovf", int'(a_ovf), 0);
    @(negedge clk);
    a_tick = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", int'(a_busy), 0);
    check("post_rst_no_done", qsize(0), 0);

    // Start coincident with a rise: that rise must not open the measurement.
    reset_all();
    seg(0, 0, 6, -1);
    seg(0, 1, 2, -1);
    seg(0, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      seg(0, 1, 2, -1);
      seg(0, 0, 2, -1);
    end
    seg(0, 0, 5, -1);
    wait_done(0, 5, "short");
    r = rec_at(0, 0);
    check("short_period", r.period, 4);
    check("short_high", r.high, 2);
    check("short_ovf", r.ovf, 0);
    check("short_count", qsize(0), CONT ? 2 : 1);

    // Narrow build, tick stuck low: WAIT_EDGE timeout.
    reset_all();
    b_start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    b_start = 1'b0;
    check("stuck0_busy", int'(b_busy), 1);
    wait_done(1, 300, "stuck0");
    r = rec_at(1, 0);
    check("stuck0_cycle", r.cyc - t0, 255);
    check("stuck0_ovf", r.ovf, 1);
    check("stuck0_period", r.period, 0);
    check("stuck0_high", r.high, 0);
    check("stuck0_busy_at_done", r.busy, 0);

    // Narrow build, stuck high after a rise, with a stray start while busy.
    reset_all();
    seg(1, 0, 5, 0);
    t0 = cyc + 1;
    b_tick = 1'b1;
    repeat (50) @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("stuck1_busy", int'(b_busy), 1);
    check("stuck1_no_early_done", qsize(1), 0);
    wait_done(1, 300, "stuck1");
    r = rec_at(1, 0);
    check("stuck1_cycle", r.cyc - t0, 2 + BMAX);
    check("stuck1_period", r.period, BMAX);
    check("stuck1_high", r.high, BMAX);
    check("stuck1_ovf", r.ovf, 1);
    repeat (5) @(negedge clk);
    check("stuck1_count", qsize(1), 1);
    check("stuck1_idle", int'(b_busy), 0);

    // Narrow build, single fall after 10 cycles then no further rise.
    reset_all();
    seg(1, 0, 5, 0);
    seg(1, 1, 10, -1);
    b_tick = 1'b0;
    wait_done(1, 300, "fall10");
    r = rec_at(1, 0);
    check("fall10_period", r.period, BMAX);
    check("fall10_high", r.high, 10);
    check("fall10_ovf", r.ovf, 1);

    // Randomized periods on the narrow build, in and beyond counter range.
    for (int k = 0; k < 8; k++) begin
      reset_all();
      if (k < 6) begin
        p = int'($urandom_range(250, 3));
        h = int'($urandom_range(p - 1, 1));
        l = p - h;
      end else begin
        p = int'($urandom_range(400, 256));
        l = int'($urandom_range(200, 1));
        h = p - l;
      end
      ep = (p > BMAX) ? BMAX : p;
      eh = (p > BMAX && h > BMAX) ? BMAX : h;
      eo = (p > BMAX) ? 1 : 0;
      seg(1, 0, l, 0);
      seg(1, 1, h, -1);
      seg(1, 0, l, -1);
      seg(1, 1, h, -1);
      seg(1, 0, 4, -1);
      wait_done(1, 400, $sformatf("rnd%0d", k));
      r = rec_at(1, 0);
      check($sformatf("rnd%0d_p%0d_period", k, p), r.period, ep);
      check($sformatf("rnd%0d_h%0d_high", k, h), r.high, eh);
      check($sformatf("rnd%0d_ovf", k), r.ovf, eo);
      check($sformatf("rnd%0d_count", k), qsize(1), 1);
    end

    // Five periods of 100 / 30 after a single start.
    reset_all();
    seg(0, 0, 5, 0);
    for (int k = 0; k < 5; k++) begin
      seg(0, 1, 30, -1);
      seg(0, 0, 70, -1);
    end
    check("cont_count", qsize(0), CONT ? 4 : 1);
    for (int i = 0; i < qsize(0); i++) begin
      r = rec_at(0, i);
      check($sformatf("cont%0d_period", i), r.period, 100);
      check($sformatf("cont%0d_high", i), r.high, 30);
      check($sformatf("cont%0d_busy", i), r.busy, CONT);
      if (i > 0) check($sformatf("cont%0d_spacing", i), r.cyc - rec_at(0, i - 1).cyc, 100);
    end
    check("cont_busy_end", int'(a_busy), CONT);

    check("no_back_to_back_done", dbl_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tick_period_meter.md
Name: tick_period_meter

Overview:
- Measures a slow periodic input, such as a 1 kHz tick/enable from a divider, in units of the system clock.
- Reports the full period (rising edge to rising edge) and the high time (rising edge to falling edge).
- Used to check divider outputs and other slow strobes in the MIPS32 platform. Results go to the debug/status path.
- Measurements are single-shot, triggered by a start pulse. Completion is a one-cycle done pulse.

Parameters:
- CNT_W, 20, width of the cycle counter and of the period/high_time results (max 2^CNT_W-1 cycles).
- SYNC_STAGES, 2, number of synchronizer flops on tick_in (legal range 2..4).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tick_in  input  1  signal under measurement; asynchronous to clk.
- start  input  1  request a measurement; sampled only in IDLE.
- busy  output  1  high while in WAIT_EDGE or MEASURE.
- done  output  1  one-cycle pulse when results update.
- period  output  CNT_W  clk cycles between two consecutive rising edges of tick_in.
- high_time  output  CNT_W  clk cycles from the rising edge to the following falling edge.
- overflow  output  1  last measurement saturated or timed out.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - Reset is asynchronous, active-low (rst_n). All flops clear immediately on assertion.
- Reset values:
  - busy=0, done=0, period=0, high_time=0, overflow=0.
  - Synchronizer flops and edge-history flop = 0. State = IDLE. Counter = 0.
- Input conditioning:
  - tick_in passes through SYNC_STAGES flops, giving s.
  - One history flop holds s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Sync latency is identical on both edges, so it cancels in period and high_time.
- State IDLE:
  - start=1: go to WAIT_EDGE, clear overflow, counter <= 0.
  - Edges arriving while in IDLE are ignored, including an edge in the same cycle as start.
- State WAIT_EDGE:
  - The counter increments each cycle as a timeout.
  - rise: go to MEASURE, counter <= 1, clear the internal "fall seen" flag.
  - Counter reaches all-ones with no rise: done=1, overflow=1, period=0, high_time=0, go to IDLE.
- State MEASURE:
  - The counter increments each cycle and saturates at all-ones.
  - fall with "fall seen"=0: latch hi_cap <= counter, set "fall seen".
  - rise: period <= counter, high_time <= hi_cap, done=1, go to IDLE.
  - Counter == all-ones and no rise: period <= all-ones, high_time <= (fall seen ? hi_cap : all-ones), overflow=1, done=1, go to IDLE.
  - rise and saturation in the same cycle: rise wins, a normal result with overflow=0.
- Counting rule: if the rising edges are seen at cycles N and N+P, then period = P. A falling edge at N+H gives high_time = H.
- Outputs:
  - busy is registered and equals (state != IDLE).
  - period, high_time and overflow hold their values between done pulses.
  - done is never high for two consecutive cycles, except in the optional continuous mode.
- start while busy: ignored.
- rst_n asserted mid-measurement: immediate return to reset values. No done pulse.

Optional Feature:
- Macro: PERIOD_METER_CONT_EN.
- Defined:
  - After a normal (non-overflow) done, the FSM goes to MEASURE instead of IDLE.
  - The terminating rise becomes the start of the next period: counter <= 1, "fall seen" cleared.
  - done pulses once per input period; busy stays 1.
  - An overflow still returns to IDLE.
  - start is needed only once.
- Not defined: single-shot only; every done returns to IDLE.

Test Plan:
- Reset: assert rst_n=0 mid-MEASURE -> all outputs 0 in the same cycle, state IDLE; after release, busy=0 until start.
- Divider-style input: tick_in period 65536 clks, high 15536 clks, start pulse -> one done, period=65536, high_time=15536, overflow=0.
- Short input: period 4 clks, high 2 clks -> period=4, high_time=2. Start coincident with a rise in IDLE -> that edge ignored; measurement is from the next two rises.
- Stuck input: tick_in held 0 (CNT_W=8 build), start -> done exactly 255 cycles after entering WAIT_EDGE, overflow=1, period=0, high_time=0.
- Stuck high after rise (CNT_W=8): rise, then no fall -> done with period=255, high_time=255, overflow=1. Variant with a fall at 10 and no second rise -> high_time=10. A start pulse while busy changes nothing.
- PERIOD_METER_CONT_EN: period 100, high 30, single start -> done every 100 cycles, each with period=100, high_time=30, busy constantly 1. Without the macro -> exactly one done.
